// File: rtl/inst_fetch.sv
// Instruction-fetch stage: keeps the fetch PC, issues word reads to
// instruction memory over a req/ack handshake and buffers returned words
// in a small in-order queue whose head is presented to decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic        Valid,
    output logic [31:0] Instruction,
    output logic [31:0] PCValP4
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [31:0]   addr_next;

    logic [31:0]   q_word [QDEPTH];
    logic [31:0]   q_pcp4 [QDEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;

    logic          deq;
    logic          enq;

    // Queue head is visible combinationally; empty queue reads as zero.
    assign Valid       = (count != '0);
    assign Instruction = Valid ? q_word[rd_ptr] : '0;
    assign PCValP4     = Valid ? q_pcp4[rd_ptr] : '0;

    // A redirect both blocks dequeue and suppresses capture of returning data.
    assign deq         = Valid & ~Stall & ~Redirect;
    assign enq         = (state == REQ) & IMemAck & ~Redirect;
    assign count_after = count + CW'(enq) - CW'(deq);

    // Next-state, next fetch PC and next request address.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        addr_next     = IMemAddr;
        case (state)
            IDLE: begin
                if (!Redirect && (count < QDEPTH_C)) begin
                    state_next = REQ;
                    addr_next  = fetch_pc;
                end
            end
            REQ: begin
                if (Redirect) begin
                    // Unacked request must still complete before the target goes out.
                    state_next = IMemAck ? IDLE : DRAIN;
                end else if (IMemAck) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    if (count_after < QDEPTH_C) begin
                        addr_next = fetch_pc + 32'd4;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (IMemAck) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (Redirect) begin
            fetch_pc_next = {RedirectPC[31:2], 2'b00};
        end
    end

    // Control state: FSM, fetch PC, registered request and queue bookkeeping.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            IMemReq  <= 1'b0;
            IMemAddr <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            IMemReq  <= (state_next != IDLE);
            IMemAddr <= addr_next;
            if (Redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_after;
                if (enq) wr_ptr <= wr_ptr + AW'(1);
                if (deq) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Queue storage; the acked request address is the word's fetch address.
    always_ff @(posedge Clk) begin
        if (enq) begin
            q_word[wr_ptr] <= IMemData;
            q_pcp4[wr_ptr] <= IMemAddr + 32'd4;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: variable-latency memory model, directed
// scenarios, then randomized stall/redirect/reset traffic checked against
// the expected program-order instruction stream.
module tb_inst_fetch;

    localparam logic [31:0] RPC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcp4;

    int checks = 0;
    int errors = 0;
    int deq_cnt = 0;

    int lat_min = 0;
    int lat_max = 0;
    int lat = 0;
    int wcnt = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pcp4;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RPC), .QDEPTH(2)) dut (
        .Clk(clk), .Rst(rst), .Stall(stall), .Redirect(redirect),
        .RedirectPC(redirect_pc), .IMemReq(req), .IMemAddr(addr),
        .IMemAck(ack), .IMemData(data), .Valid(valid),
        .Instruction(instr), .PCValP4(pcp4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Expected program order from a start PC: sequential words.
    task automatic load_stream(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back('{mem_word(pc + 32'(4 * i)), pc + 32'(4 * i) + 32'd4});
        end
    endtask

    // Main-process step: inputs are driven and outputs inspected here.
    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    // Memory model: acks after a random number of wait cycles per request.
    initial begin
        ack  = 1'b0;
        data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (ack) begin
                wcnt = 0;
                lat  = int'($urandom_range(lat_max, lat_min));
            end
            if (rst || !req) begin
                ack  = 1'b0;
                wcnt = 0;
            end else if (wcnt >= lat) begin
                ack = 1'b1;
            end else begin
                ack = 1'b0;
                wcnt++;
            end
            data = ack ? mem_word(addr) : $urandom();
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each dequeue.
    initial begin
        logic        p_req   = 1'b0;
        logic        p_ack   = 1'b0;
        logic        p_rst   = 1'b1;
        logic        p_redir = 1'b0;
        logic [31:0] p_addr  = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #3;
            if (p_rst) begin
                check1("reset_req", req, 1'b0);
                check1("reset_valid", valid, 1'b0);
            end else begin
                if (p_req && !p_ack) begin
                    check1("req_held", req, 1'b1);
                    check32("addr_held", addr, p_addr);
                end
                if (p_redir) check1("flush_valid", valid, 1'b0);
            end
            check32("addr_align", {30'b0, addr[1:0]}, 32'h0);
            if (!valid) begin
                check32("empty_instr", instr, 32'h0);
                check32("empty_pcp4", pcp4, 32'h0);
            end
            if (!rst && valid && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deq_unexpected: got pcp4 %h expected no instruction", pcp4);
                end else begin
                    e = exp_q.pop_front();
                    check32("sb_instr", instr, e.word);
                    check32("sb_pcp4", pcp4, e.pcp4);
                    deq_cnt++;
                end
            end
            p_req   = req;
            p_ack   = ack;
            p_rst   = rst;
            p_redir = redirect;
            p_addr  = addr;
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [31:0] h;
        logic [31:0] a;
        logic        found;
        int          r;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        load_stream(RPC);
        cyc(); cyc();
        check1("rst_req", req, 1'b0);
        check32("rst_addr", addr, 32'h0);
        check1("rst_valid", valid, 1'b0);
        check32("rst_instr", instr, 32'h0);
        check32("rst_pcp4", pcp4, 32'h0);
        rst = 1'b0;

        // Zero-wait streaming with wrap from 0xFFFFFFFC.
        cyc();
        check1("first_req", req, 1'b1);
        check32("first_addr", addr, RPC);
        check1("first_valid_low", valid, 1'b0);
        cyc();
        check1("first_valid", valid, 1'b1);
        check32("wrap_pcp4", pcp4, 32'h0);
        check32("wrap_instr", instr, mem_word(RPC));
        check32("second_addr", addr, 32'h0);
        for (int k = 1; k < 8; k++) begin
            cyc();
            check1("stream_valid", valid, 1'b1);
            check32("stream_pcp4", pcp4, 32'(4 * k));
        end

        // Stall: queue fills, request stops, head held.
        h = pcp4;
        stall = 1'b1;
        repeat (5) cyc();
        check1("stall_valid", valid, 1'b1);
        check1("stall_req_off", req, 1'b0);
        check32("stall_head", pcp4, h);
        stall = 1'b0;
        repeat (4) cyc();

        // Redirect with an outstanding 3-cycle request: drain, then target.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            if (req && !ack) found = 1'b1;
        end
        check1("wait_outstanding", found, 1'b1);
        a = addr;
        redirect = 1'b1; redirect_pc = 32'h40; load_stream(32'h40);
        cyc();
        redirect = 1'b0;
        for (int i = 0; i < 20 && req; i++) begin
            check32("drain_addr", addr, a);
            check1("drain_valid", valid, 1'b0);
            cyc();
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (valid) found = 1'b1;
            else cyc();
        end
        check1("wait_target_valid", found, 1'b1);
        check32("target_pcp4", pcp4, 32'h44);
        check32("target_instr", instr, mem_word(32'h40));

        // Redirect coinciding with ack; unaligned target.
        lat_min = 0; lat_max = 0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            if (req && ack) found = 1'b1;
        end
        check1("wait_ack", found, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h103; load_stream(32'h100);
        cyc();
        redirect = 1'b0;
        check1("ra_valid", valid, 1'b0);
        check1("ra_idle", req, 1'b0);
        cyc();
        check1("ra_req", req, 1'b1);
        check32("ra_addr", addr, 32'h100);
        cyc();
        check1("ra_valid2", valid, 1'b1);
        check32("ra_pcp4", pcp4, 32'h104);

        // Redirect while stalled flushes the queue.
        stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (valid && !req) found = 1'b1;
        end
        check1("wait_full", found, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h300; load_stream(32'h300);
        cyc();
        redirect = 1'b0; stall = 1'b0;
        check1("stall_flush", valid, 1'b0);

        // Reset while draining.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            if (req && !ack) found = 1'b1;
        end
        check1("wait_outstanding2", found, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h500; load_stream(32'h500);
        cyc();
        redirect = 1'b0;
        check1("drain_req", req, 1'b1);
        rst = 1'b1; load_stream(RPC);
        cyc();
        rst = 1'b0;
        check1("drst_req", req, 1'b0);
        check1("drst_valid", valid, 1'b0);
        cyc();
        check1("drst_req2", req, 1'b1);
        check32("drst_addr", addr, RPC);

        // Randomized traffic.
        lat_min = 0; lat_max = 3;
        deq_cnt = 0;
        for (int i = 0; i < 2500; i++) begin
            cyc();
            stall = ($urandom_range(0, 9) < 3);
            r = int'($urandom_range(0, 199));
            rst = (r == 0);
            redirect = (r >= 1 && r < 13);
            if (rst) begin
                load_stream(RPC);
            end else if (redirect) begin
                redirect_pc = $urandom();
                load_stream({redirect_pc[31:2], 2'b00});
            end
        end
        rst = 1'b0; redirect = 1'b0; stall = 1'b0;
        repeat (4) cyc();
        check1("progress", deq_cnt > 200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage directly upstream of the register-decode stage in the 5-stage MIPS pipeline. Keeps the fetch PC and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency. Buffers returned words in a small in-order queue and presents Instruction/PCValP4 to decode. Takes stall from hazard logic and branch redirects (NewPCVal, taken condition) from decode.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
QDEPTH, 2, instruction queue entries; power of two, 2..8

Ports:
Clk  input  1  clock, all state on rising edge
Rst  input  1  synchronous active-high reset
Stall  input  1  decode cannot accept; hold queue head
Redirect  input  1  taken branch/jump this cycle
RedirectPC  input  32  new fetch target (NewPCVal)
IMemReq  output  1  read request, registered
IMemAddr  output  32  word address, registered, [1:0]=0
IMemAck  input  1  read data valid this cycle; legal only while IMemReq=1
IMemData  input  32  instruction word, sampled when IMemAck=1
Valid  output  1  Instruction/PCValP4 hold a real instruction
Instruction  output  32  queue-head instruction word
PCValP4  output  32  queue-head fetch address + 4

Behaviour:
- Reset (Rst high at edge): FetchPC=RESET_PC, queue empty, Count=0, state IDLE, IMemReq=0, IMemAddr=0, Valid=0. Instruction and PCValP4 read 0 while empty. Reset mid-transaction drops the request; instruction memory shares Rst.
- Queue: entries {word, addr+4}. Head drives Instruction/PCValP4 combinationally. Valid = (Count != 0).
- Dequeue (deq) = Valid & ~Stall & ~Redirect.
- Enqueue on IMemAck in state REQ only. Slot is guaranteed by the issue rule, so the queue never overflows.
- States:
  - IDLE: IMemReq=0. If ~Redirect and Count < QDEPTH, next cycle is REQ with IMemAddr=FetchPC.
  - REQ: IMemReq=1, IMemAddr stable until ack.
    - On ack without Redirect: enqueue; FetchPC += 4.
    - If (Count + 1 - deq) < QDEPTH, stay REQ with IMemAddr=FetchPC+4 next cycle (back-to-back, 1 instr/cycle). Otherwise go IDLE.
  - DRAIN: IMemReq=1 with the old address until ack. Data is discarded. Then IDLE.
- Ack may arrive in the first REQ cycle (zero-wait) or any later cycle.
- Redirect (priority over Stall and ack):
  - Flush queue (Count=0). FetchPC = {RedirectPC[31:2], 2'b00}.
  - In REQ without ack this cycle, go DRAIN.
  - In REQ with ack this cycle, discard the data and go IDLE.
  - In DRAIN, update FetchPC and stay DRAIN.
  - In IDLE, stay IDLE; the request goes out the next cycle.
- Latency: redirect in cycle t, memory zero-wait, no drain → IMemReq for target at t+2, Valid at t+3.
- Arithmetic: FetchPC and PCValP4 are mod 2^32; 0xFFFFFFFC+4 = 0x0.
- Stall never alters IMemAddr of an outstanding request. It only stops dequeue; issue halts via the Count rule.
- Simultaneous enqueue and dequeue: Count unchanged, order preserved.

Test Plan:
1. RESET_PC=0, zero-wait memory (ack whenever req), Stall=0 → IMemReq rises 1 cycle after reset release at addr 0x0. Valid the next cycle with PCValP4=0x4, then 0x8, 0xC, ... one per cycle, no gaps.
2. Zero-wait memory, Stall high 5 cycles after first Valid → Count reaches 2, IMemReq drops, head fixed (PCValP4=0x4). Release → sequence continues 0x4, 0x8, 0xC with no loss or duplicate.
3. 3-cycle memory latency, Redirect with RedirectPC=0x40 while the request to 0x10 is outstanding → IMemAddr holds 0x10 until ack. That word is not enqueued; Valid=0 until the 0x40 word returns. First PCValP4=0x44.
4. Redirect and IMemAck in the same cycle → acked word dropped. Next IMemAddr=RedirectPC. Redirect during Stall also flushes: Valid=0 next cycle.
5. RedirectPC=0x103 → IMemAddr=0x100, PCValP4=0x104.
6. RESET_PC=0xFFFFFFFC → first PCValP4=0x0, second fetch at IMemAddr=0x0. Rst asserted in DRAIN → IMemReq=0 next cycle, Valid=0, FetchPC=RESET_PC.
